// File: rtl/seqdet_pkg.sv
// seqdet_pkg: types and default widths shared by the seqdet stream controller.
//   state_t : controller FSM states (IDLE, RUN, DRAIN, DONE)
//   DATA_W  : default pattern width in bits
//   LEN_W   : default width of the run-length input
//   CNT_W   : default width of the match counter
package seqdet_pkg;

  localparam int DATA_W = 24;
  localparam int LEN_W  = 16;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/seqdet_stream_ctrl.sv
// seqdet_stream_ctrl: streams a software-loaded pattern word MSB-first and
// rotating onto the serial detector input, counts detector match pulses and
// flags completion with a one-cycle done pulse.
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   load, load_data : load the pattern register (IDLE only)
//   start, run_len  : begin a run of run_len bits (IDLE only)
//   x               : serial bit driven to the detector (0 outside RUN)
//   z               : detector match output, sampled in RUN and DRAIN
//   busy            : high while in RUN or DRAIN
//   done            : one-cycle pulse in the DONE state
//   match_cnt       : saturating count of z highs in the current/last run
//   sat             : sticky flag, match_cnt reached all-ones during the run
module seqdet_stream_ctrl #(
  parameter int DATA_W = seqdet_pkg::DATA_W,
  parameter int LEN_W  = seqdet_pkg::LEN_W,
  parameter int CNT_W  = seqdet_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic [LEN_W-1:0]  run_len,
  output logic              x,
  input  logic              z,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              sat
);

  import seqdet_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  // Rotate left by one: the bit just streamed re-enters at the LSB.
  function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] v);
    return {v[DATA_W-2:0], v[DATA_W-1]};
  endfunction

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   pat_q,   pat_d;
  logic [LEN_W-1:0]    rem_q,   rem_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic                sat_q,   sat_d;
  logic                x_q,     x_d;
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;

  logic [CNT_W-1:0]    cnt_step_s;
  logic                sat_step_s;

  // Saturating match count and sticky flag for one sampled z.
  always_comb begin
    cnt_step_s = cnt_q;
    if (z && (cnt_q != CNT_MAX)) begin
      cnt_step_s = cnt_q + CNT_ONE;
    end else begin
      cnt_step_s = cnt_q;
    end
    sat_step_s = sat_q | (cnt_step_s == CNT_MAX);
  end

  // FSM next-state, pattern rotation, down-counter and match counter.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          pat_d = load_data;
        end else begin
          pat_d = pat_q;
        end
        if (start) begin
          rem_d = run_len;
          cnt_d = {CNT_W{1'b0}};
          sat_d = 1'b0;
          if (run_len != {LEN_W{1'b0}}) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        pat_d = rotl1(pat_q);
        rem_d = rem_q - LEN_ONE;
        cnt_d = cnt_step_s;
        sat_d = sat_step_s;
        if (rem_q == LEN_ONE) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      // One extra sample catches the detector's response to the last bit.
      DRAIN: begin
        cnt_d   = cnt_step_s;
        sat_d   = sat_step_s;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from next state so they leave a flop, not the inputs.
  always_comb begin
    if (state_d == RUN) begin
      x_d = pat_d[DATA_W-1];
    end else begin
      x_d = 1'b0;
    end
    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= {DATA_W{1'b0}};
      rem_q   <= {LEN_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      sat_q   <= 1'b0;
      x_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x         = x_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign match_cnt = cnt_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_seqdet_stream_ctrl.sv
// Directed bench for seqdet_stream_ctrl. Instance u_dut (default widths) is
// fed by a small bench-side "1001" overlapping detector on z; instance
// u_sat (CNT_W=2) has z tied high to exercise saturation.
module tb_seqdet_stream_ctrl;

  localparam logic [23:0] PAT_A = 24'hC90948;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [23:0] load_data;
  logic        start;
  logic [15:0] run_len;
  logic        x;
  logic        z;
  logic        busy;
  logic        done;
  logic [7:0]  match_cnt;
  logic        sat;

  logic        load_b;
  logic [23:0] load_data_b;
  logic        start_b;
  logic [15:0] run_len_b;
  logic        x_b;
  logic        z_b;
  logic        busy_b;
  logic        done_b;
  logic [1:0]  cnt_b;
  logic        sat_b;

  logic [3:0]  sh;
  int          checks = 0;
  int          errors = 0;
  int          dcount;

  always #5 clk = ~clk;

  seqdet_stream_ctrl u_dut (
    .clk(clk), .rst(rst), .load(load), .load_data(load_data),
    .start(start), .run_len(run_len), .x(x), .z(z), .busy(busy),
    .done(done), .match_cnt(match_cnt), .sat(sat)
  );

  seqdet_stream_ctrl #(.DATA_W(24), .LEN_W(16), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .load(load_b), .load_data(load_data_b),
    .start(start_b), .run_len(run_len_b), .x(x_b), .z(z_b), .busy(busy_b),
    .done(done_b), .match_cnt(cnt_b), .sat(sat_b)
  );

  // Stand-in detector: z is high the cycle after x has shown 1,0,0,1.
  always @(posedge clk) begin
    if (rst) sh <= 4'd0;
    else     sh <= {sh[2:0], x};
  end
  assign z   = (sh == 4'b1001);
  assign z_b = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Called in cycle k+1 after a start; checks the stream, DRAIN and DONE.
  task automatic stream(input logic [23:0] pat, input int n, input string tag, input int exp_cnt);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_x"}, 32'(x), 32'(pat[23 - (i % 24)]));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done_early"}, 32'(done), 32'd0);
      tick();
    end
    chk({tag, "_drain_x"}, 32'(x), 32'd0);
    chk({tag, "_drain_busy"}, 32'(busy), 32'd1);
    chk({tag, "_drain_done"}, 32'(done), 32'd0);
    tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    if (exp_cnt >= 0) chk({tag, "_cnt"}, 32'(match_cnt), 32'(exp_cnt));
    tick();
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_data = 24'd0; start = 1'b0; run_len = 16'd0;
    load_b = 1'b0; load_data_b = 24'd0; start_b = 1'b0; run_len_b = 16'd0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);

    // Basic 24-bit stream: four "1001" windows in C90948.
    load = 1'b1; load_data = PAT_A; tick(); load = 1'b0;
    start = 1'b1; run_len = 16'd24; tick(); start = 1'b0;
    stream(PAT_A, 24, "basic", 4);

    // 48-bit run continues the rotation from the original word.
    start = 1'b1; run_len = 16'd48; tick(); start = 1'b0;
    stream(PAT_A, 48, "wrap", 8);

    // Zero length: done next cycle, counter cleared from 8.
    start = 1'b1; run_len = 16'd0; tick(); start = 1'b0;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_x", 32'(x), 32'd0);
    chk("zero_cnt", 32'(match_cnt), 32'd0);
    tick();
    chk("zero_done_after", 32'(done), 32'd0);
    chk("zero_busy_after", 32'(busy), 32'd0);

    // start/load pulsed mid-run must be ignored.
    start = 1'b1; run_len = 16'd24; tick(); start = 1'b0;
    dcount = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c <= 24) chk("ign_x", 32'(x), 32'(PAT_A[24 - c]));
      else         chk("ign_x_tail", 32'(x), 32'd0);
      if (done) dcount++;
      if (c == 26) chk("ign_done_time", 32'(done), 32'd1);
      if (c == 5) begin start = 1'b1; load = 1'b1; load_data = 24'hFFFFFF; end
      else        begin start = 1'b0; load = 1'b0; end
      tick();
    end
    chk("ign_done_count", 32'(dcount), 32'd1);
    start = 1'b1; run_len = 16'd4; tick(); start = 1'b0;
    stream(PAT_A, 4, "ign_pat", 0);

    // load and start together: the new word is the one streamed.
    load = 1'b1; load_data = 24'h800001; start = 1'b1; run_len = 16'd24;
    tick(); load = 1'b0; start = 1'b0;
    stream(24'h800001, 24, "ldst", 0);

    // Saturation with a 2-bit counter and z held high.
    start_b = 1'b1; run_len_b = 16'd10; tick(); start_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        chk("sat_cnt2", 32'(cnt_b), 32'd2);
        chk("sat_flag2", 32'(sat_b), 32'd0);
      end
      if (i == 3) begin
        chk("sat_cnt3", 32'(cnt_b), 32'd3);
        chk("sat_flag3", 32'(sat_b), 32'd1);
      end
      tick();
    end
    tick();
    chk("sat_done", 32'(done_b), 32'd1);
    chk("sat_cnt_done", 32'(cnt_b), 32'd3);
    chk("sat_flag_done", 32'(sat_b), 32'd1);
    tick();
    start_b = 1'b1; tick(); start_b = 1'b0;
    chk("sat_clr_cnt", 32'(cnt_b), 32'd0);
    chk("sat_clr_flag", 32'(sat_b), 32'd0);
    repeat (12) tick();

    // Reset in cycle k+10 of a 24-bit run.
    load = 1'b1; load_data = PAT_A; tick(); load = 1'b0;
    start = 1'b1; run_len = 16'd24; tick(); start = 1'b0;
    repeat (9) tick();
    chk("mid_cnt", 32'(match_cnt), 32'd2);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstm_x", 32'(x), 32'd0);
    chk("rstm_busy", 32'(busy), 32'd0);
    chk("rstm_cnt", 32'(match_cnt), 32'd0);
    chk("rstm_sat", 32'(sat), 32'd0);
    chk("rstm_done", 32'(done), 32'd0);
    dcount = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) dcount++;
      tick();
    end
    chk("rstm_no_done", 32'(dcount), 32'd0);
    start = 1'b1; run_len = 16'd4; tick(); start = 1'b0;
    stream(24'h000000, 4, "rstm_pat0", 0);
    load = 1'b1; load_data = PAT_A; start = 1'b1; run_len = 16'd24;
    tick(); load = 1'b0; start = 1'b0;
    stream(PAT_A, 24, "fresh", 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seqdet_stream_ctrl.md
# seqdet_stream_ctrl

- Sequencing controller for the serial sequence detector (`seqdet`).
- Holds a software-loaded pattern word and streams it MSB-first, rotating, onto the detector's `x` input for a programmed number of bits.
- Counts detector match pulses on `z` and reports completion with a one-cycle `done` pulse.
- Replaces ad-hoc bench stimulus with a reusable block that feeds and scores `seqdet` in-system.

## Interface
- `DATA_W`, 24: pattern width in bits (≥2).
- `LEN_W`, 16: width of `run_len`.
- `CNT_W`, 8: width of `match_cnt` (≥2).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  load `load_data` into the pattern register (honoured only in IDLE).
- `load_data`  in  DATA_W  pattern word.
- `start`  in  1  begin a run (honoured only in IDLE).
- `run_len`  in  LEN_W  number of bits to stream; sampled on start acceptance.
- `x`  out  1  serial bit to the detector.
- `z`  in  1  detector match output.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle completion pulse.
- `match_cnt`  out  CNT_W  number of `z` highs seen in the current/last run.
- `sat`  out  1  sticky: `match_cnt` hit all-ones during the run.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
- **Reset values:** state IDLE, pattern register 0, remaining-bit counter 0, `x`=0, `busy`=0, `done`=0, `match_cnt`=0, `sat`=0.
- **IDLE, `load`=1:** pattern register ← `load_data`. In any other state `load` is ignored.
- **IDLE, `start`=1:**
  - Latch `run_len` into the remaining-bit counter.
  - Clear `match_cnt` and `sat`.
  - Next state is RUN if `run_len`≠0, otherwise DONE.
- **`load` and `start` in the same IDLE cycle:** the new `load_data` is the pattern streamed.
- **RUN:**
  - `x` = pattern[DATA_W-1].
  - Each cycle the pattern rotates left by one (MSB → LSB) and the counter decrements.
  - When the counter is 1, next state is DRAIN.
- **DRAIN:** exactly one cycle. `x`=0. Captures the detector's response to the final bit. Next state is DONE.
- **DONE:** exactly one cycle. `done`=1. Next state is IDLE.
- **`x` outside RUN:** 0.
- **Match counting:** `z` is sampled in every RUN and DRAIN cycle; each high increments `match_cnt`. It saturates at 2^CNT_W−1, and `sat` sets on reaching that value. `match_cnt` and `sat` hold after DONE until the next accepted start.
- **Pattern after a run:** the pattern register keeps its rotated value. A new run without `load` continues the rotation.
- **Ignored inputs:** `start` in RUN, DRAIN or DONE is ignored (no queuing).
- **`rst` mid-run:** every register returns to its reset value on that edge. No `done` pulse is produced.

## Timing
- `start` accepted at edge k → first pattern bit on `x` during cycle k+1.
- For `run_len`=N≥1:
  - RUN spans cycles k+1 … k+N.
  - DRAIN is cycle k+N+1.
  - `done`=1 in cycle k+N+2.
  - IDLE at k+N+3; `start` is accepted again from then.
- For `run_len`=0: `done`=1 in cycle k+1, `busy` never asserts, `x` stays 0.
- `x`, `busy` and `done` are decoded from registered state with no input-to-output combinational path. `z` is registered into the counter only.
- `match_cnt`'s final value is visible in the `done` cycle.

## Structure
- Shared package `seqdet_pkg`:
  - state enum typedef (IDLE, RUN, DRAIN, DONE);
  - default width constants `DATA_W`, `LEN_W`, `CNT_W`.
- Single module, no sub-module. The rotate register, down-counter, saturating match counter and FSM are small enough to live together.

## Test plan
- **Basic stream:** load 24'hC90948, start with `run_len`=24 → `x` = 1,1,0,0,1,0,0,1,0,0,0,0,1,0,0,1,0,1,0,0,1,0,0,0 on cycles k+1…k+24; `done` at k+26; `busy` high k+1…k+25.
- **Wrap-around and counting:** same pattern, `run_len`=48, real `seqdet` attached → `x` repeats the 24-bit sequence twice; `match_cnt` equals the reference-model count over 48 bits plus the DRAIN sample.
- **Saturation:** `CNT_W`=2, `z` forced high, `run_len`=10 → `match_cnt`=3 and `sat`=1 at `done`; the next start clears both.
- **Zero length:** `run_len`=0 → `done` the cycle after start, `busy`=0 throughout, `x`=0, `match_cnt`=0.
- **Ignored controls:**
  - `start` and `load`=24'hFFFFFF pulsed at cycle k+5 of a 24-bit run → stream unchanged, a single `done`, pattern not overwritten.
  - `load`+`start` in the same IDLE cycle with 24'h800001 → `x`=1,0,…,0,1.
- **Reset mid-run:** assert `rst` at cycle k+10 → next cycle `x`=0, `busy`=0, `match_cnt`=0, pattern=0; no `done`; a fresh load/start afterwards runs normally.
